// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared sample width, measurement FSM states and N decode
package dds_pkg;

    localparam int DDS_BITWIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } meas_state_e;

    // Periods to measure: n_sel 0..3 selects 1, 2, 4 or 8
    function automatic logic [3:0] n_decode(input logic [1:0] n_sel);
        return 4'd1 << n_sel;
    endfunction

endpackage

// File: rtl/wave_xdet.sv
// rtl/wave_xdet.sv - hysteresis rising-crossing detector around midscale
module wave_xdet
    import dds_pkg::*;
#(
    parameter int BITWIDTH = DDS_BITWIDTH,
    parameter int HYST     = 8
) (
    input  logic [BITWIDTH-1:0] din_i,
    input  logic                din_valid_i,
    input  logic                lo_i,
    output logic                xing_o,
    output logic                lo_set_o
);

    localparam int MID = 1 << (BITWIDTH - 1);
    localparam logic [BITWIDTH-1:0] LO_TH = BITWIDTH'(MID - HYST);
    localparam logic [BITWIDTH-1:0] HI_TH = BITWIDTH'(MID + HYST);

    // A crossing needs a prior excursion below the low threshold, so noise
    // inside the band around midscale never fires.
    assign xing_o   = din_valid_i && lo_i && (din_i >= HI_TH);
    assign lo_set_o = din_valid_i && (din_i < LO_TH);

endmodule

// File: rtl/wave_meas.sv
// rtl/wave_meas.sv - period and peak measurement over N periods of a sampled wave
module wave_meas
    import dds_pkg::*;
#(
    parameter int BITWIDTH  = DDS_BITWIDTH,
    parameter int CNT_WIDTH = 20,
    parameter int HYST      = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 meas_ena,
    input  logic [1:0]           n_sel,
    input  logic                 din_valid,
    input  logic [BITWIDTH-1:0]  din,
    input  logic                 res_ready,
    output logic                 res_valid,
    output logic [CNT_WIDTH-1:0] period_cnt,
    output logic [BITWIDTH-1:0]  peak_max,
    output logic [BITWIDTH-1:0]  peak_min,
    output logic                 ovf,
    output logic                 busy
);

    meas_state_e          state_q;
    logic [3:0]           n_q;
    logic [3:0]           xcnt_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 lo_q;
    logic [BITWIDTH-1:0]  trk_max_q;
    logic [BITWIDTH-1:0]  trk_min_q;
    logic                 res_valid_q;
    logic                 busy_q;
    logic                 ovf_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic [BITWIDTH-1:0]  pmax_q;
    logic [BITWIDTH-1:0]  pmin_q;

    logic                 xing;
    logic                 lo_set;
    logic                 lo_d;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 cnt_sat;
    logic                 last_xing;
    logic [BITWIDTH-1:0]  trk_max_d;
    logic [BITWIDTH-1:0]  trk_min_d;

    wave_xdet #(
        .BITWIDTH(BITWIDTH),
        .HYST    (HYST)
    ) u_xdet (
        .din_i      (din),
        .din_valid_i(din_valid),
        .lo_i       (lo_q),
        .xing_o     (xing),
        .lo_set_o   (lo_set)
    );

    // Next values of the per-sample trackers; only committed on valid samples
    always_comb begin
        lo_d      = xing ? 1'b0 : (lo_set ? 1'b1 : lo_q);
        cnt_d     = cnt_q + CNT_WIDTH'(1);
        cnt_sat   = (cnt_d == {CNT_WIDTH{1'b1}});
        last_xing = xing && ((xcnt_q + 4'd1) == n_q);
        trk_max_d = (din > trk_max_q) ? din : trk_max_q;
        trk_min_d = (din < trk_min_q) ? din : trk_min_q;
    end

    // Measurement FSM with registered result, status and tracking state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            n_q         <= 4'd1;
            xcnt_q      <= '0;
            cnt_q       <= '0;
            lo_q        <= 1'b0;
            trk_max_q   <= '0;
            trk_min_q   <= '1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            period_q    <= '0;
            pmax_q      <= '0;
            pmin_q      <= '0;
        end else if (!meas_ena) begin
            // Abort from any state; the last result stays on the outputs
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_SYNC;
                    busy_q    <= 1'b1;
                    n_q       <= n_decode(n_sel);
                    cnt_q     <= '0;
                    xcnt_q    <= '0;
                    lo_q      <= 1'b0;
                    trk_max_q <= '0;
                    trk_min_q <= '1;
                end
                ST_SYNC: begin
                    if (din_valid) begin
                        lo_q <= lo_d;
                        if (xing) begin
                            // Window starts after the aligning crossing
                            state_q   <= ST_MEAS;
                            cnt_q     <= '0;
                            xcnt_q    <= '0;
                            trk_max_q <= '0;
                            trk_min_q <= '1;
                        end else begin
                            cnt_q <= cnt_d;
                            if (cnt_sat) begin
                                state_q     <= ST_DONE;
                                busy_q      <= 1'b0;
                                res_valid_q <= 1'b1;
                                ovf_q       <= 1'b1;
                                period_q    <= '1;
                                pmax_q      <= trk_max_q;
                                pmin_q      <= trk_min_q;
                            end
                        end
                    end
                end
                ST_MEAS: begin
                    if (din_valid) begin
                        lo_q      <= lo_d;
                        cnt_q     <= cnt_d;
                        trk_max_q <= trk_max_d;
                        trk_min_q <= trk_min_d;
                        if (xing) begin
                            xcnt_q <= xcnt_q + 4'd1;
                        end
                        // The closing crossing takes priority over saturation
                        if (last_xing || cnt_sat) begin
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            res_valid_q <= 1'b1;
                            ovf_q       <= !last_xing;
                            period_q    <= last_xing ? cnt_d : '1;
                            pmax_q      <= trk_max_d;
                            pmin_q      <= trk_min_d;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        // Consumer took the result; rearm straight into SYNC
                        state_q     <= ST_SYNC;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        n_q         <= n_decode(n_sel);
                        cnt_q       <= '0;
                        xcnt_q      <= '0;
                        lo_q        <= 1'b0;
                        trk_max_q   <= '0;
                        trk_min_q   <= '1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid  = res_valid_q;
    assign busy       = busy_q;
    assign ovf        = ovf_q;
    assign period_cnt = period_q;
    assign peak_max   = pmax_q;
    assign peak_min   = pmin_q;

endmodule

// File: tb/tb_wave_meas.sv
// tb/tb_wave_meas.sv - directed self-checking bench for wave_meas
module tb_wave_meas;

    logic        clk = 1'b0;
    logic        rstn;
    logic        meas_ena;
    logic        ena8;
    logic [1:0]  n_sel;
    logic        din_valid;
    logic [9:0]  din;
    logic        res_ready;

    logic        res_valid;
    logic [19:0] period_cnt;
    logic [9:0]  peak_max;
    logic [9:0]  peak_min;
    logic        ovf;
    logic        busy;

    logic        rv8;
    logic [7:0]  period8;
    logic [9:0]  pmax8;
    logic [9:0]  pmin8;
    logic        ovf8;
    logic        busy8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wave_meas dut (
        .clk       (clk),
        .rstn      (rstn),
        .meas_ena  (meas_ena),
        .n_sel     (n_sel),
        .din_valid (din_valid),
        .din       (din),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .period_cnt(period_cnt),
        .peak_max  (peak_max),
        .peak_min  (peak_min),
        .ovf       (ovf),
        .busy      (busy)
    );

    wave_meas #(.CNT_WIDTH(8)) dut8 (
        .clk       (clk),
        .rstn      (rstn),
        .meas_ena  (ena8),
        .n_sel     (n_sel),
        .din_valid (din_valid),
        .din       (din),
        .res_ready (res_ready),
        .res_valid (rv8),
        .period_cnt(period8),
        .peak_max  (pmax8),
        .peak_min  (pmin8),
        .ovf       (ovf8),
        .busy      (busy8)
    );

    task automatic go_idle();
        @(negedge clk);
        meas_ena  = 1'b0;
        ena8      = 1'b0;
        res_ready = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Enable, optionally change n_sel after SYNC entry, feed the square wave
    task automatic run_window(input logic [1:0] nsel, input bit gappy,
                              input bit change_n, output bit got);
        int idx;
        int k;
        @(negedge clk);
        meas_ena  = 1'b1;
        n_sel     = nsel;
        din_valid = 1'b0;
        @(negedge clk);
        if (change_n) n_sel = 2'd0;
        idx = 0;
        k   = 0;
        got = 1'b0;
        while (k < 3000 && !got) begin
            if (gappy && (k % 2 == 1)) begin
                din_valid = 1'b0;
            end else begin
                din_valid = 1'b1;
                din       = ((idx % 16) < 8) ? 10'd0 : 10'd1023;
                idx++;
            end
            @(negedge clk);
            k++;
            if (res_valid) got = 1'b1;
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; meas_ena = 1'b0; ena8 = 1'b0; n_sel = 2'd0;
        din_valid = 1'b0; din = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
        checks++; if (period_cnt !== 20'd0) begin errors++; $display("FAIL rst_period got %0d exp 0", period_cnt); end
        checks++; if (peak_max !== 10'd0) begin errors++; $display("FAIL rst_peak_max got %0d exp 0", peak_max); end
        checks++; if (peak_min !== 10'd0) begin errors++; $display("FAIL rst_peak_min got %0d exp 0", peak_min); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_n1();
        bit got;
        run_window(2'd0, 1'b0, 1'b0, got);
        checks++; if (!got) begin errors++; $display("FAIL n1_valid got 0 exp 1"); end
        checks++; if (period_cnt !== 20'd16) begin errors++; $display("FAIL n1_period got %0d exp 16", period_cnt); end
        checks++; if (peak_max !== 10'd1023) begin errors++; $display("FAIL n1_peak_max got %0d exp 1023", peak_max); end
        checks++; if (peak_min !== 10'd0) begin errors++; $display("FAIL n1_peak_min got %0d exp 0", peak_min); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL n1_ovf got %b exp 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n1_busy got %b exp 0", busy); end
        go_idle();
    endtask

    task automatic test_n8();
        bit got;
        run_window(2'd3, 1'b0, 1'b1, got);
        checks++; if (!got) begin errors++; $display("FAIL n8_valid got 0 exp 1"); end
        checks++; if (period_cnt !== 20'd128) begin errors++; $display("FAIL n8_period got %0d exp 128", period_cnt); end
        go_idle();
    endtask

    task automatic test_n8_gappy();
        bit got;
        run_window(2'd3, 1'b1, 1'b0, got);
        checks++; if (!got) begin errors++; $display("FAIL n8gap_valid got 0 exp 1"); end
        checks++; if (period_cnt !== 20'd128) begin errors++; $display("FAIL n8gap_period got %0d exp 128", period_cnt); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL n8gap_ovf got %b exp 0", ovf); end
        go_idle();
    endtask

    task automatic test_hold();
        bit got;
        run_window(2'd0, 1'b0, 1'b0, got);
        checks++; if (!got) begin errors++; $display("FAIL hold_valid got 0 exp 1"); end
        for (int c = 0; c < 20; c++) begin
            din_valid = 1'b1;
            din       = 10'($urandom_range(0, 1023));
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || period_cnt !== 20'd16 || peak_max !== 10'd1023 ||
                peak_min !== 10'd0 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cyc %0d got rv=%b p=%0d mx=%0d mn=%0d o=%b exp 1/16/1023/0/0",
                         c, res_valid, period_cnt, peak_max, peak_min, ovf);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL hold_hs_rv got %b exp 0", res_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_hs_busy got %b exp 1", busy); end
        go_idle();
    endtask

    task automatic test_abort();
        bit got;
        @(negedge clk);
        meas_ena = 1'b1;
        n_sel    = 2'd0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            din_valid = 1'b1;
            din       = ((i % 16) < 8) ? 10'd0 : 10'd1023;
            @(negedge clk);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b exp 1", busy); end
        meas_ena  = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_rv got %b exp 0", res_valid); end
        checks++; if (period_cnt !== 20'd16) begin errors++; $display("FAIL abort_retain got %0d exp 16", period_cnt); end
        run_window(2'd0, 1'b0, 1'b0, got);
        checks++; if (!got) begin errors++; $display("FAIL abort_rerun_valid got 0 exp 1"); end
        checks++; if (period_cnt !== 20'd16) begin errors++; $display("FAIL abort_rerun_period got %0d exp 16", period_cnt); end
        go_idle();
    endtask

    // Narrow counter: 1 enable cycle plus 255 valid samples to saturation
    task automatic test_timeout(input bit toggle, input string nm);
        int cyc;
        @(negedge clk);
        ena8      = 1'b1;
        din_valid = 1'b1;
        din       = toggle ? 10'd510 : 10'd512;
        cyc       = 0;
        while (cyc < 400 && !rv8) begin
            @(negedge clk);
            cyc++;
            if (toggle) din = (din == 10'd510) ? 10'd514 : 10'd510;
        end
        checks++; if (cyc !== 256) begin errors++; $display("FAIL %s_cycles got %0d exp 256", nm, cyc); end
        checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL %s_ovf got %b exp 1", nm, ovf8); end
        checks++; if (period8 !== 8'd255) begin errors++; $display("FAIL %s_period got %0d exp 255", nm, period8); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        meas_ena = 1'b1;
        n_sel    = 2'd0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            din_valid = 1'b1;
            din       = ((i % 16) < 8) ? 10'd0 : 10'd1023;
            @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (period_cnt !== 20'd0) begin errors++; $display("FAIL rmid_period got %0d exp 0", period_cnt); end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = 10'd1023;
            @(negedge clk);
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rmid_rv got %b exp 0", res_valid); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_n1();
        test_n8();
        test_n8_gappy();
        test_hold();
        test_abort();
        test_timeout(1'b0, "dc_ovf");
        test_timeout(1'b1, "noxing");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wave_meas.md
WAVE_MEAS -- requirements
Module: wave_meas

Interface
REQ-001 Parameter BITWIDTH, default 10: sample width, the same width as the DDS output.
REQ-002 Parameter CNT_WIDTH, default 20: width of the sample counter.
REQ-003 Parameter HYST, default 8: crossing hysteresis in LSBs around midscale.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 Port meas_ena, input, 1 bit: run enable; low forces IDLE.
REQ-007 Port n_sel, input, 2 bits: periods to measure, N = 1, 2, 4 or 8.
REQ-008 Port din_valid, input, 1 bit: din is a valid sample this cycle.
REQ-009 Port din, input, BITWIDTH bits: unsigned sample; midscale MID = 2^(BITWIDTH-1).
REQ-010 Port res_ready, input, 1 bit: consumer accepts the result.
REQ-011 Port res_valid, output, 1 bit: result fields are valid.
REQ-012 Port period_cnt, output, CNT_WIDTH bits: valid samples spanning N periods.
REQ-013 Port peak_max, output, BITWIDTH bits: maximum sample in the window.
REQ-014 Port peak_min, output, BITWIDTH bits: minimum sample in the window.
REQ-015 Port ovf, output, 1 bit: counter saturated; the result is a timeout.
REQ-016 Port busy, output, 1 bit: high in SYNC or MEAS.

Function
REQ-017 Only cycles with din_valid=1 are processed; other cycles hold all state except the FSM reaction to meas_ena.
REQ-018 Crossing detector uses a lo flag.
- lo is set when din < MID-HYST.
- A rising crossing fires when lo=1 and din >= MID+HYST; lo clears on that same sample.
REQ-019 FSM states are IDLE, SYNC, MEAS and DONE.
REQ-020 IDLE -> SYNC when meas_ena=1.
- Latch N from n_sel.
- Clear the counter, the crossing count and lo.
REQ-021 In SYNC, the first rising crossing -> MEAS.
- Set the counter to 0.
- Set peak_max=0 and peak_min=all-ones.
REQ-022 In MEAS, every valid sample does all of the following:
- Increments the counter.
- Updates the max/min registers, including the crossing sample.
- Increments the crossing count on each crossing.
REQ-023 When the Nth crossing in MEAS occurs:
- Latch period_cnt, peak_max and peak_min, with ovf=0.
- Go to DONE; res_valid is high on the next cycle.
REQ-024 The counter also runs in SYNC.
- If it reaches all-ones in SYNC or MEAS: go to DONE with ovf=1 and period_cnt=all-ones.
- peak fields then hold the values tracked so far.
REQ-025 In DONE, res_valid=1 and all result fields stay stable until res_valid and res_ready are both high.
- Then go to SYNC if meas_ena=1, else to IDLE.
REQ-026 meas_ena=0 in any state -> IDLE on the next edge; res_valid deasserts; result registers retain their last values.
REQ-027 A crossing and saturation on the same sample: the crossing wins and ovf=0.
REQ-028 n_sel changes during a measurement have no effect until the next SYNC entry.

Reset
REQ-029 Asynchronous reset sets state to IDLE.
REQ-030 Asynchronous reset sets res_valid, busy, ovf, period_cnt and peak_max to 0.
REQ-031 Asynchronous reset sets peak_min to 0 and lo to 0.
REQ-032 A reset asserted mid-measurement discards the measurement; no res_valid follows reset release until a new full window completes.

Structure
REQ-033 The shared dds package holds BITWIDTH, the state enumeration and the N decode of n_sel.
REQ-034 One sub-module, wave_xdet, holds the hysteresis crossing detector: din, din_valid and lo in, crossing pulse out.

Verification
REQ-035 Square wave, 8 samples of 0 then 8 of 1023 repeating, N=1 -> period_cnt=16, peak_max=1023, peak_min=0, ovf=0.
REQ-036 Same wave with N=8 -> period_cnt=128; with din_valid low every other cycle -> still 128.
REQ-037 DC din=512 with CNT_WIDTH=8 -> after 255 valid samples, res_valid=1, ovf=1, period_cnt=255.
REQ-038 Result pending with res_ready held low for 20 cycles -> fields stable; the first handshake returns to SYNC, and busy=1 on the next cycle.
REQ-039 meas_ena dropped in MEAS -> IDLE on the next cycle, res_valid=0; re-enable gives a fresh correct 16-count result.
REQ-040 Toggling din between 510 and 514 (inside HYST=8) -> no crossing, stays in SYNC until timeout.
